scr1_pipe_dbga_ms: RTL

Parametrised debug agent between the DBGC command interface and the pipeline (EXU/IFU). It controls halt/resume with a bounded drain phase and a programmable timeout. It adds multi-instruction stepping (N instructions per step command) and a single-cycle command/ack protocol. It records the cause of each debug-mode entry for DBGC.

---
 rtl/scr1_pipe_dbga_ms_if.sv | 24 ++
 rtl/scr1_pipe_dbga_ms.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_dbga_ms_if.sv
// DBGC-side command/ack and debug data register signals of the debug agent.
interface scr1_pipe_dbga_ms_if #(
    parameter int STEP_W = 8,
    parameter int DDR_W  = 32
);
    logic              cmd_req;
    logic [1:0]        cmd;
    logic [STEP_W-1:0] step_cnt;
    logic              cmd_ack;
    logic              cmd_nack;
    logic [DDR_W-1:0]  ddr_in;
    logic              ddr_we;
    logic [DDR_W-1:0]  ddr_out;

    modport master (
        output cmd_req, cmd, step_cnt, ddr_in, ddr_we,
        input  cmd_ack, cmd_nack, ddr_out
    );

    modport slave (
        input  cmd_req, cmd, step_cnt, ddr_in, ddr_we,
        output cmd_ack, cmd_nack, ddr_out
    );
endinterface

// File: rtl/scr1_pipe_dbga_ms.sv
// Debug agent: halt/resume with bounded drain, N-instruction stepping, entry cause capture.
// Optional SCR1_DBGA_HALT_CNT_EN adds a saturating halted-cycle counter output.
module scr1_pipe_dbga_ms #(
    parameter int TIMEOUT_W = 6,
    parameter int STEP_W    = 8,
    parameter int DDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scr1_pipe_dbga_ms_if.slave   dbgc,
    input  logic [2:0]           dmode_en,
    input  logic                 fetch_src_dbgc,
    input  logic                 exu_busy,
    input  logic                 instret,
    input  logic                 exu_exc_req,
    input  logic                 brkpt,
    input  logic                 exu_init_pc,
    output logic                 exu_no_commit,
    output logic                 fetch_dbgc,
    output logic                 dbg_halted,
    output logic                 dbg_run2halt,
    output logic                 dbg_halt2run,
    output logic                 dbg_run_start,
    output logic [3:0]           cause,
    output logic                 except,
    output logic                 timeout
`ifdef SCR1_DBGA_HALT_CNT_EN
    ,
    output logic [31:0]          halt_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_HALT   = 2'd0,
        CMD_RESUME = 2'd1,
        CMD_STEP   = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_e;

    state_e                state_q, state_d;
    logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [3:0]            cause_d;
    logic                  except_d, timeout_d, fetch_d;
    logic                  ack, nack, run2halt, halt2run;
    logic                  cmd_halt, rst_e, brk_e, entry, sstep_hit, sstep_halt;

    // Entry terms only count once the EXU is idle; the breakpoint term alone drives no_commit.
    assign rst_e    = ~exu_busy & dmode_en[1] & exu_init_pc;
    assign brk_e    = ~exu_busy & dmode_en[2] & brkpt;
    assign entry    = rst_e | brk_e;
    assign cmd_halt = dbgc.cmd_req & (dbgc.cmd == CMD_HALT);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        step_d        = step_q;
        cause_d       = cause;
        except_d      = except;
        timeout_d     = timeout;
        fetch_d       = fetch_dbgc;
        ack           = 1'b0;
        nack          = 1'b0;
        run2halt      = 1'b0;
        halt2run      = 1'b0;
        exu_no_commit = 1'b0;
        sstep_hit     = 1'b0;
        sstep_halt    = 1'b0;

        if (fetch_dbgc && instret) fetch_d = 1'b0;

        unique case (state_q)
            ST_RUN, ST_STEP: begin
                exu_no_commit = dmode_en[2] & brkpt;
                if (state_q == ST_STEP && instret) begin
                    sstep_hit = (step_q == STEP_W'(1));
                    if (step_q != '0) step_d = step_q - STEP_W'(1);
                end
                sstep_halt = sstep_hit & dmode_en[0];

                if (dbgc.cmd_req && !cmd_halt) nack = 1'b1;

                if ((cmd_halt && !exu_busy) || entry || sstep_halt) begin
                    ack       = cmd_halt;
                    run2halt  = 1'b1;
                    state_d   = ST_HALTED;
                    cause_d   = {cmd_halt, sstep_halt, brk_e, rst_e};
                    except_d  = exu_exc_req;
                    timeout_d = 1'b0;
                end else if (cmd_halt) begin
                    state_d = ST_DRAIN;
                    tmo_d   = '1;
                end else if (sstep_hit) begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (tmo_q != '0) tmo_d = tmo_q - TIMEOUT_W'(1);
                // A completion response owns the ack/nack wires over a colliding new command.
                if (!exu_busy || tmo_q == '0) begin
                    ack       = ~exu_busy;
                    nack      = exu_busy;
                    run2halt  = 1'b1;
                    state_d   = ST_HALTED;
                    cause_d   = {1'b1, 1'b0, brk_e, rst_e};
                    except_d  = exu_exc_req;
                    timeout_d = exu_busy;
                end else if (dbgc.cmd_req) begin
                    nack = 1'b1;
                end
            end

            ST_HALTED: begin
                if (dbgc.cmd_req) begin
                    unique case (dbgc.cmd)
                        CMD_RESUME: begin
                            ack      = 1'b1;
                            halt2run = 1'b1;
                            state_d  = ST_RUN;
                            fetch_d  = fetch_src_dbgc;
                        end
                        CMD_STEP: begin
                            ack      = 1'b1;
                            halt2run = 1'b1;
                            state_d  = ST_STEP;
                            step_d   = (dbgc.step_cnt == '0) ? STEP_W'(1) : dbgc.step_cnt;
                        end
                        default: nack = 1'b1;
                    endcase
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            tmo_q         <= '1;
            step_q        <= '0;
            cause         <= '0;
            except        <= 1'b0;
            timeout       <= 1'b0;
            fetch_dbgc    <= 1'b0;
            dbg_run_start <= 1'b0;
            dbgc.ddr_out  <= '0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            step_q        <= step_d;
            cause         <= cause_d;
            except        <= except_d;
            timeout       <= timeout_d;
            fetch_dbgc    <= fetch_d;
            dbg_run_start <= halt2run;
            if (dbgc.ddr_we) dbgc.ddr_out <= dbgc.ddr_in;
        end
    end

`ifdef SCR1_DBGA_HALT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_cycles <= '0;
        end else if (run2halt) begin
            halt_cycles <= '0;
        end else if (state_q == ST_HALTED && halt_cycles != '1) begin
            halt_cycles <= halt_cycles + 32'd1;
        end
    end
`endif

    assign dbgc.cmd_ack  = ack;
    assign dbgc.cmd_nack = nack;
    assign dbg_run2halt  = run2halt;
    assign dbg_halt2run  = halt2run;
    assign dbg_halted    = (state_q == ST_HALTED);

endmodule
